// File: rtl/notg_pipe.sv
// notg_pipe: stream inverter with pass/invert/mask/alternate modes and a STAGES-deep elastic pipeline.
// Define NOTG_PIPE_PARITY_EN to add out_parity, carried alongside the data.
module notg_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef NOTG_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d [STAGES];
  logic              phase;
  logic              acc;
  logic [WIDTH-1:0]  xf;

  // A stage advances if it, or any stage downstream, has a hole,
  // or the consumer takes the tail word.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v[j]) adv[k] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0];
  assign acc      = in_valid && in_ready;

  always_comb begin
    xf = in_data;
    case (mode)
      2'b00: xf = in_data;
      2'b01: xf = ~in_data;
      2'b10: xf = in_data ^ mask;
      2'b11: xf = phase ? ~in_data : in_data;
      default: xf = in_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      phase <= 1'b0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      if (acc) phase <= (mode == 2'b11) ? ~phase : 1'b0;
      if (adv[0]) begin
        v[0] <= acc;
        if (acc) d[0] <= xf;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
    end
  end

`ifdef NOTG_PIPE_PARITY_EN
  logic [STAGES-1:0] par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
    end else begin
      if (adv[0] && acc) par[0] <= ^xf;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k] && v[k-1]) par[k] <= par[k-1];
      end
    end
  end

  assign out_parity = par[STAGES-1];
`endif

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign busy      = |v;

endmodule

// File: tb/tb_notg_pipe.sv
// tb_notg_pipe: directed bench for notg_pipe (WIDTH=8, STAGES=2).
// Expected words are queued on acceptance and compared when they leave.
module tb_notg_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] mask = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef NOTG_PIPE_PARITY_EN
  logic         out_parity;
  bit           pq [$];
`endif

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] q [$];

  always #5 clk = ~clk;

  notg_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef NOTG_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle, account for both handshakes, then cross one edge.
  task automatic tick(output bit acc);
    logic [W-1:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid & out_ready), 0);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
`ifdef NOTG_PIPE_PARITY_EN
        chk("out_parity_sb", 32'(out_parity), 32'(pq.pop_front()));
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(logic [W-1:0] dat, logic [1:0] md,
                      logic [W-1:0] mk, logic [W-1:0] e);
    bit a;
    a = 1'b0;
    in_valid = 1'b1;
    in_data  = dat;
    mode     = md;
    mask     = mk;
    for (int i = 0; i < 20 && !a; i++) begin
      tick(a);
      if (a) begin
        q.push_back(e);
`ifdef NOTG_PIPE_PARITY_EN
        pq.push_back(^e);
`endif
      end
    end
    if (!a) chk("accept_timeout", 32'(a), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(a);
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    bit a;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // pass, latency and busy
    out_ready = 1'b1;
    beat(8'hA5, 2'b00, 8'h00, 8'hA5);
    chk("lat_early_valid", 32'(out_valid), 0);
    chk("lat_busy", 32'(busy), 1);
    tick(a);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h0A5);
    tick(a);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);

    // invert and masked invert
    beat(8'h3C, 2'b01, 8'h00, 8'hC3);
    beat(8'h3C, 2'b10, 8'h0F, 8'h33);
    drain();

    // alternate, then phase cleared by a non-alternate beat
    beat(8'h00, 2'b11, 8'h00, 8'h00);
    beat(8'h00, 2'b11, 8'h00, 8'hFF);
    beat(8'h00, 2'b11, 8'h00, 8'h00);
    beat(8'h00, 2'b00, 8'h00, 8'h00);
    beat(8'h00, 2'b11, 8'h00, 8'h00);
    drain();

    // backpressure
    out_ready = 1'b0;
    beat(8'h01, 2'b00, 8'h00, 8'h01);
    beat(8'h02, 2'b00, 8'h00, 8'h02);
    in_valid = 1'b1;
    in_data  = 8'h03;
    mode     = 2'b00;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_out_data", 32'(out_data), 32'h01);
    tick(a);
    chk("full_no_accept", 32'(a), 0);
    tick(a);
    chk("hold_out_data", 32'(out_data), 32'h01);
    chk("hold_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    beat(8'h03, 2'b00, 8'h00, 8'h03);
    chk("simul_busy", 32'(busy), 1);
    chk("simul_out_data", 32'(out_data), 32'h02);
    beat(8'h04, 2'b00, 8'h00, 8'h04);
    drain();

    // asynchronous reset with two words in flight
    out_ready = 1'b0;
    beat(8'h11, 2'b00, 8'h00, 8'h11);
    beat(8'h22, 2'b00, 8'h00, 8'h22);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_busy", 32'(busy), 0);
    q.delete();
`ifdef NOTG_PIPE_PARITY_EN
    pq.delete();
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick(a);
      chk("no_stale", 32'(out_valid), 0);
    end

`ifdef NOTG_PIPE_PARITY_EN
    beat(8'h07, 2'b00, 8'h00, 8'h07);
    tick(a);
    chk("par_07", 32'(out_parity), 1);
    beat(8'h03, 2'b00, 8'h00, 8'h03);
    tick(a);
    chk("par_03_data", 32'(out_data), 32'h03);
    chk("par_03", 32'(out_parity), 0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
